// File: rtl/text_line_renderer.sv
// One-line, 16-character text overlay: addresses the 8x16 font ROM from the scan position and
// serializes the returned row byte into text_on/text_bit with a fixed 2-clk latency. Optional blink: TEXT_BLINK_EN.
module text_line_renderer #(
    parameter int TEXT_X0 = 256,
    parameter int TEXT_Y0 = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        video_on,
    input  logic        wr_en,
    input  logic [3:0]  wr_idx,
    input  logic [7:0]  wr_char,
    output logic [10:0] rom_addr,
    input  logic [7:0]  rom_data,
    output logic        text_on,
    output logic        text_bit
);

`ifdef TEXT_BLINK_EN
    localparam int CW = 8;
`else
    localparam int CW = 7;
`endif

    localparam logic [10:0] X_LO = 11'(TEXT_X0);
    localparam logic [10:0] X_HI = 11'(TEXT_X0 + 128);
    localparam logic [10:0] Y_LO = 11'(TEXT_Y0);
    localparam logic [10:0] Y_HI = 11'(TEXT_Y0 + 16);
    localparam logic [3:0]  COL0 = 4'(TEXT_X0 / 8);

    logic [CW-1:0] line_buf [16];
    logic          in_box;
    logic [3:0]    col;
    logic [3:0]    row;
    logic          in_box_d;
    logic [2:0]    bit_d;
    logic          vis;

    assign in_box = video_on
                 && ({1'b0, pixel_x} >= X_LO) && ({1'b0, pixel_x} < X_HI)
                 && ({1'b0, pixel_y} >= Y_LO) && ({1'b0, pixel_y} < Y_HI);
    // TEXT_X0 is a multiple of 8, so the slot index needs no borrow from the low bits
    assign col = pixel_x[6:3] - COL0;
    assign row = pixel_y[3:0];

    always_comb begin
        rom_addr = {7'h00, row};
        if (in_box)
            rom_addr = {line_buf[col][6:0], row};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++)
                line_buf[i] <= '0;
        end else if (wr_en) begin
            line_buf[wr_idx] <= wr_char[CW-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_box_d <= 1'b0;
            bit_d    <= 3'd0;
            text_on  <= 1'b0;
            text_bit <= 1'b0;
        end else begin
            in_box_d <= in_box;
            bit_d    <= pixel_x[2:0];
            text_on  <= in_box_d;
            // bit 7 of the row byte is the leftmost pixel, so index with 7 - bit_d
            text_bit <= in_box_d & rom_data[~bit_d] & vis;
        end
    end

`ifdef TEXT_BLINK_EN
    logic       blink_d;
    logic       prev_zero;
    logic [4:0] cnt;
    logic       at_zero;

    assign at_zero = (pixel_x == 10'd0) && (pixel_y == 10'd0);
    assign vis     = ~(blink_d & cnt[4]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_d   <= 1'b0;
            prev_zero <= 1'b0;
            cnt       <= 5'd0;
        end else begin
            blink_d   <= line_buf[col][7];
            prev_zero <= at_zero;
            if (at_zero && !prev_zero)
                cnt <= cnt + 5'd1;
        end
    end
`else
    logic unused_blink_attr;
    assign unused_blink_attr = wr_char[7];
    assign vis = 1'b1;
`endif

endmodule

// File: tb/tb_text_line_renderer.sv
// Directed bench for text_line_renderer with a registered font ROM model; outputs are
// checked against expectations queued two vectors earlier.
module tb_text_line_renderer;
    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  pixel_x, pixel_y;
    logic        video_on, wr_en;
    logic [3:0]  wr_idx;
    logic [7:0]  wr_char;
    logic [10:0] rom_addr;
    logic [7:0]  rom_data;
    logic        text_on, text_bit;

    int total = 0;
    int bad   = 0;
    logic [1:0] expq[$];
    string      tagq[$];

    text_line_renderer #(.TEXT_X0(256), .TEXT_Y0(32)) dut (
        .clk(clk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .video_on(video_on), .wr_en(wr_en), .wr_idx(wr_idx), .wr_char(wr_char),
        .rom_addr(rom_addr), .rom_data(rom_data), .text_on(text_on), .text_bit(text_bit)
    );

    always #5 clk = ~clk;

    // code 0 is blank, 'P' row 2 is 0xFC, every other glyph row is 0x81
    function automatic logic [7:0] font(input logic [10:0] a);
        if (a[10:4] == 7'h00) return 8'h00;
        if (a == 11'h502)     return 8'hFC;
        return 8'h81;
    endfunction

    always @(posedge clk) rom_data <= font(rom_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic vec(input logic [9:0] x, input logic [9:0] y, input logic v,
                       input logic we, input logic [3:0] wi, input logic [7:0] wc,
                       input logic eon, input logic ebit, input string tag);
        logic [1:0] e;
        string t;
        @(posedge clk); #1;
        pixel_x = x; pixel_y = y; video_on = v;
        wr_en = we; wr_idx = wi; wr_char = wc;
        expq.push_back({eon, ebit});
        tagq.push_back(tag);
        #1;
        if (expq.size() > 2) begin
            e = expq.pop_front();
            t = tagq.pop_front();
            chk({t, "_on"},  {31'd0, text_on},  {31'd0, e[1]});
            chk({t, "_bit"}, {31'd0, text_bit}, {31'd0, e[0]});
        end
    endtask

    task automatic px(input logic [9:0] x, input logic [9:0] y, input logic v,
                      input logic eon, input logic ebit, input string tag);
        vec(x, y, v, 1'b0, 4'd0, 8'h00, eon, ebit, tag);
    endtask

    task automatic wr(input logic [3:0] i, input logic [7:0] c);
        vec(10'd1, 10'd0, 1'b0, 1'b1, i, c, 1'b0, 1'b0, "wr");
    endtask

    task automatic seed_after_reset();
        expq.delete(); tagq.delete();
        expq.push_back(2'b00); tagq.push_back("rel0");
        expq.push_back(2'b00); tagq.push_back("rel1");
    endtask

    initial begin
        logic hid;
        reset = 1'b1;
        pixel_x = 10'd1; pixel_y = 10'd0; video_on = 1'b0;
        wr_en = 1'b0; wr_idx = 4'd0; wr_char = 8'h00;
        #2;
        chk("rst_on",  {31'd0, text_on},  32'd0);
        chk("rst_bit", {31'd0, text_bit}, 32'd0);
        pixel_x = 10'd256; pixel_y = 10'd34; video_on = 1'b1;
        #1 chk("rst_addr", {21'd0, rom_addr}, 32'h002);
        pixel_x = 10'd1; pixel_y = 10'd0; video_on = 1'b0;
        #20 reset = 1'b0;
        seed_after_reset();

        wr(4'd0, 8'h50); wr(4'd1, 8'h4F); wr(4'd2, 8'h4E); wr(4'd3, 8'h47);

        // "PONG" row 2 sweep across the left edge of the box
        px(10'd255, 10'd34, 1'b1, 1'b0, 1'b0, "x255");
        px(10'd256, 10'd34, 1'b1, 1'b1, 1'b1, "x256");
        chk("addr_P2", {21'd0, rom_addr}, 32'h502);
        px(10'd257, 10'd34, 1'b1, 1'b1, 1'b1, "x257");
        px(10'd258, 10'd34, 1'b1, 1'b1, 1'b1, "x258");
        px(10'd259, 10'd34, 1'b1, 1'b1, 1'b1, "x259");
        px(10'd260, 10'd34, 1'b1, 1'b1, 1'b1, "x260");
        px(10'd261, 10'd34, 1'b1, 1'b1, 1'b1, "x261");
        px(10'd262, 10'd34, 1'b1, 1'b1, 1'b0, "x262");
        px(10'd263, 10'd34, 1'b1, 1'b1, 1'b0, "x263");
        px(10'd264, 10'd34, 1'b1, 1'b1, 1'b1, "x264");
        px(10'd265, 10'd34, 1'b1, 1'b1, 1'b0, "x265");

        // right edge (slot 15 is blank) and y edges
        px(10'd383, 10'd34, 1'b1, 1'b1, 1'b0, "x383");
        px(10'd384, 10'd34, 1'b1, 1'b0, 1'b0, "x384");
        chk("addr_out", {21'd0, rom_addr}, 32'h002);
        px(10'd256, 10'd31, 1'b1, 1'b0, 1'b0, "y31");
        px(10'd256, 10'd32, 1'b1, 1'b1, 1'b1, "y32");
        px(10'd256, 10'd47, 1'b1, 1'b1, 1'b1, "y47");
        px(10'd256, 10'd48, 1'b1, 1'b0, 1'b0, "y48");
        px(10'd256, 10'd34, 1'b0, 1'b0, 1'b0, "vid_off");
        chk("addr_vidoff", {21'd0, rom_addr}, 32'h002);

        // held pixel repeats the same output
        px(10'd256, 10'd34, 1'b1, 1'b1, 1'b1, "hold0");
        px(10'd256, 10'd34, 1'b1, 1'b1, 1'b1, "hold1");
        px(10'd256, 10'd34, 1'b1, 1'b1, 1'b1, "hold2");

        // write/read collision on slot 1
        wr(4'd1, 8'h4E);
        vec(10'd264, 10'd34, 1'b1, 1'b1, 4'd1, 8'h4F, 1'b1, 1'b1, "coll0");
        chk("coll_old", {21'd0, rom_addr}, 32'h4E2);
        px(10'd264, 10'd34, 1'b1, 1'b1, 1'b1, "coll1");
        chk("coll_new", {21'd0, rom_addr}, 32'h4F2);
        // back-to-back writes to one slot keep the last value
        wr(4'd2, 8'h11); wr(4'd2, 8'h22);
        px(10'd272, 10'd34, 1'b1, 1'b1, 1'b1, "b2b");
        chk("b2b_addr", {21'd0, rom_addr}, 32'h222);

        // asynchronous reset mid-line
        px(10'd256, 10'd34, 1'b1, 1'b1, 1'b1, "pre_rst0");
        px(10'd256, 10'd34, 1'b1, 1'b1, 1'b1, "pre_rst1");
        px(10'd256, 10'd34, 1'b1, 1'b1, 1'b1, "pre_rst2");
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_on",  {31'd0, text_on},  32'd0);
        chk("mid_rst_bit", {31'd0, text_bit}, 32'd0);
        chk("mid_rst_addr", {21'd0, rom_addr}, 32'h002);
        @(posedge clk); #1;
        pixel_x = 10'd264;
        #1 chk("rst_slot1", {21'd0, rom_addr}, 32'h002);
        pixel_x = 10'd1; pixel_y = 10'd0; video_on = 1'b0;
        #10 reset = 1'b0;
        seed_after_reset();
        px(10'd256, 10'd34, 1'b1, 1'b1, 1'b0, "post_rst");

        // blink attribute on slot 0, plain glyph on slot 1, across 40 frames
        wr(4'd0, 8'hD0); wr(4'd1, 8'h4F);
        for (int f = 0; f < 40; f++) begin
`ifdef TEXT_BLINK_EN
            hid = (f >= 16) && (f < 32);
`else
            hid = 1'b0;
`endif
            px(10'd256, 10'd34, 1'b1, 1'b1, ~hid, $sformatf("blink_s0_f%0d", f));
            px(10'd264, 10'd34, 1'b1, 1'b1, 1'b1, $sformatf("blink_s1_f%0d", f));
            px(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, "sof");
            px(10'd1, 10'd0, 1'b0, 1'b0, 1'b0, "idle");
        end

        px(10'd1, 10'd0, 1'b0, 1'b0, 1'b0, "flush0");
        px(10'd1, 10'd0, 1'b0, 1'b0, 1'b0, "flush1");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
